// File: rtl/instruction_sequencer_pkg.sv
// rtl/instruction_sequencer_pkg.sv - shared types and constants for the instruction sequencer
// Optional single-step mode is selected with SINGLE_STEP_EN.
package instruction_sequencer_pkg;

   localparam int INSTRUCTION_WIDTH_DEFAULT = 16;

   localparam logic [15:0] HALT_WORD       = 16'hFFFF;
   localparam logic [15:0] NOP_INSTRUCTION = 16'h9000;

   typedef enum logic [1:0] {
      LOAD,
      LOADED,
      RUN,
      DONE
   } seq_state_t;

endpackage

// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - loader/cpu-facing signal bundle of the instruction sequencer
// step_in exists only when SINGLE_STEP_EN is defined.
interface instruction_sequencer_if
   import instruction_sequencer_pkg::*;
#(
   parameter int DEPTH             = 256,
   parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic [7:0]                   load_byte;
   logic                         load_byte_valid;
   logic                         load_byte_ready;
   logic                         start;
`ifdef SINGLE_STEP_EN
   logic                         step_in;
`endif
   logic [INSTRUCTION_WIDTH-1:0] current_instruction;
   logic                         instruction_valid;
   logic [ADDR_WIDTH-1:0]        program_counter;
   logic                         busy;
   logic                         done;
   logic                         overflow_error;

   modport master (
      output load_byte, load_byte_valid, start,
`ifdef SINGLE_STEP_EN
      output step_in,
`endif
      input  load_byte_ready, current_instruction, instruction_valid,
      input  program_counter, busy, done, overflow_error
   );

   modport slave (
      input  load_byte, load_byte_valid, start,
`ifdef SINGLE_STEP_EN
      input  step_in,
`endif
      output load_byte_ready, current_instruction, instruction_valid,
      output program_counter, busy, done, overflow_error
   );

endinterface

// File: rtl/instruction_buffer.sv
// rtl/instruction_buffer.sv - single-port DEPTH x INSTRUCTION_WIDTH RAM, sync write, registered read
// Contents are never cleared; a program survives until it is overwritten by a new load.
module instruction_buffer #(
   parameter int DEPTH             = 256,
   parameter int INSTRUCTION_WIDTH = 16,
   localparam int ADDR_WIDTH       = $clog2(DEPTH)
) (
   input  logic                         clock_in,
   input  logic                         write_enable,
   input  logic [ADDR_WIDTH-1:0]        address,
   input  logic [INSTRUCTION_WIDTH-1:0] write_data,
   output logic [INSTRUCTION_WIDTH-1:0] read_data
);

   logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock_in) begin
      if (write_enable) begin
         mem[address] <= write_data;
      end
      read_data <= mem[address];
   end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - loads a byte-stream program, then streams words to the cpu until halt
// SINGLE_STEP_EN adds step_in: each pulse presents one word two cycles later.
module instruction_sequencer
   import instruction_sequencer_pkg::*;
#(
   parameter int DEPTH             = 256,
   parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT
) (
   input  logic                    clock_in,
   input  logic                    power_on_reset_signal,
   instruction_sequencer_if.slave  bus
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0]        ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0]        ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [INSTRUCTION_WIDTH-1:0] HALT      = INSTRUCTION_WIDTH'(HALT_WORD);
   localparam logic [INSTRUCTION_WIDTH-1:0] NOP       = INSTRUCTION_WIDTH'(NOP_INSTRUCTION);

   seq_state_t                   state;
   logic [ADDR_WIDTH-1:0]        write_pointer;
   logic [ADDR_WIDTH-1:0]        read_pointer;
   logic [ADDR_WIDTH-1:0]        pc;
   logic                         high_phase;
   logic [7:0]                   high_byte;
   logic [INSTRUCTION_WIDTH-1:0] instruction_reg;
   logic                         valid_reg;
   logic                         overflow_reg;
   logic                         wrapped;

   logic                         ram_write;
   logic [ADDR_WIDTH-1:0]        ram_address;
   logic [INSTRUCTION_WIDTH-1:0] ram_write_data;
   logic [INSTRUCTION_WIDTH-1:0] read_data;
   logic                         consume;
   logic                         halt_hit;

`ifdef SINGLE_STEP_EN
   logic step_q;

   always_ff @(posedge clock_in) begin
      if (power_on_reset_signal) begin
         step_q <= 1'b0;
      end else begin
         step_q <= bus.step_in;
      end
   end

   assign consume = step_q;
`else
   assign consume = 1'b1;
`endif

   // read_data always holds word (read_pointer - 1); when not consuming, re-read it to hold it.
   always_comb begin
      ram_write      = (state == LOAD) && bus.load_byte_valid && !high_phase;
      ram_write_data = INSTRUCTION_WIDTH'({high_byte, bus.load_byte});
      halt_hit       = (read_data == HALT) || wrapped;
      case (state)
         LOAD:    ram_address = write_pointer;
         RUN:     ram_address = consume ? read_pointer : read_pointer - ADDR_ONE;
         default: ram_address = '0;
      endcase
   end

   instruction_buffer #(
      .DEPTH             (DEPTH),
      .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
   ) u_buffer (
      .clock_in     (clock_in),
      .write_enable (ram_write),
      .address      (ram_address),
      .write_data   (ram_write_data),
      .read_data    (read_data)
   );

   always_ff @(posedge clock_in) begin
      if (power_on_reset_signal) begin
         state           <= LOAD;
         write_pointer   <= '0;
         read_pointer    <= '0;
         pc              <= '0;
         high_phase      <= 1'b1;
         high_byte       <= '0;
         instruction_reg <= NOP;
         valid_reg       <= 1'b0;
         overflow_reg    <= 1'b0;
         wrapped         <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (bus.load_byte_valid) begin
                  if (high_phase) begin
                     high_byte  <= bus.load_byte;
                     high_phase <= 1'b0;
                  end else begin
                     high_phase    <= 1'b1;
                     write_pointer <= write_pointer + ADDR_ONE;
                     if (ram_write_data == HALT) begin
                        state <= LOADED;
                     end else if (write_pointer == ADDR_LAST) begin
                        overflow_reg <= 1'b1;
                        state        <= LOADED;
                     end
                  end
               end
            end
            LOADED, DONE: begin
               // Word 0 is read on the same edge, so it is ready in the first RUN cycle.
               if (bus.start) begin
                  state        <= RUN;
                  read_pointer <= ADDR_ONE;
                  pc           <= '0;
                  wrapped      <= 1'b0;
               end
            end
            RUN: begin
               if (consume && halt_hit) begin
                  state           <= DONE;
                  instruction_reg <= NOP;
                  valid_reg       <= 1'b0;
               end else if (consume) begin
                  instruction_reg <= read_data;
                  valid_reg       <= 1'b1;
                  pc              <= read_pointer - ADDR_ONE;
                  read_pointer    <= read_pointer + ADDR_ONE;
                  if (read_pointer == '0) begin
                     wrapped <= 1'b1;
                  end
               end else begin
                  instruction_reg <= NOP;
                  valid_reg       <= 1'b0;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign bus.load_byte_ready     = (state == LOAD);
   assign bus.busy                = (state == RUN);
   assign bus.done                = (state == DONE);
   assign bus.current_instruction = instruction_reg;
   assign bus.instruction_valid   = valid_reg;
   assign bus.program_counter     = pc;
   assign bus.overflow_error      = overflow_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed self-checking bench for instruction_sequencer
// Free-run checks by default; single-step checks when SINGLE_STEP_EN is defined.
module tb_instruction_sequencer;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   instruction_sequencer_if #(.DEPTH(256), .INSTRUCTION_WIDTH(16)) bus  ();
   instruction_sequencer_if #(.DEPTH(4),   .INSTRUCTION_WIDTH(16)) bus4 ();

   instruction_sequencer #(.DEPTH(256), .INSTRUCTION_WIDTH(16)) dut (
      .clock_in              (clk),
      .power_on_reset_signal (rst),
      .bus                   (bus)
   );

   instruction_sequencer #(.DEPTH(4), .INSTRUCTION_WIDTH(16)) dut4 (
      .clock_in              (clk),
      .power_on_reset_signal (rst),
      .bus                   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  prog_main [8];
   logic [7:0]  prog_ovf  [8];
   logic [15:0] exp_main  [3];
   logic [15:0] exp_ovf   [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_tests++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic send(input logic [7:0] b);
      bus.load_byte       = b;
      bus.load_byte_valid = 1'b1;
      tick();
      bus.load_byte_valid = 1'b0;
   endtask

   task automatic send4(input logic [7:0] b);
      bus4.load_byte       = b;
      bus4.load_byte_valid = 1'b1;
      tick();
      bus4.load_byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic load_main();
      for (int i = 0; i < 8; i++) send(prog_main[i]);
   endtask

`ifndef SINGLE_STEP_EN
   task automatic run_main(input string tag);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk({tag, "_n1_valid"}, bus.instruction_valid, 1'b0);
      chk({tag, "_n1_busy"}, bus.busy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("%s_word%0d", tag, i), bus.current_instruction, exp_main[i]);
         chk($sformatf("%s_valid%0d", tag, i), bus.instruction_valid, 1'b1);
         chk($sformatf("%s_pc%0d", tag, i), bus.program_counter, i);
      end
      tick();
      chk({tag, "_end_valid"}, bus.instruction_valid, 1'b0);
      chk({tag, "_end_nop"}, bus.current_instruction, 16'h9000);
      chk({tag, "_end_done"}, bus.done, 1'b1);
      chk({tag, "_end_busy"}, bus.busy, 1'b0);
      chk({tag, "_end_ovf"}, bus.overflow_error, 1'b0);
   endtask
`endif

   initial begin
      n_tests = 0;
      n_fail  = 0;
      prog_main = '{8'h00, 8'h05, 8'h10, 8'h07, 8'h50, 8'h00, 8'hFF, 8'hFF};
      prog_ovf  = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
      exp_main  = '{16'h0005, 16'h1007, 16'h5000};
      exp_ovf   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

      rst = 1'b1;
      bus.load_byte = '0;  bus.load_byte_valid = 1'b0;  bus.start = 1'b0;
      bus4.load_byte = '0; bus4.load_byte_valid = 1'b0; bus4.start = 1'b0;
`ifdef SINGLE_STEP_EN
      bus.step_in  = 1'b0;
      bus4.step_in = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;

      chk("rst_instr", bus.current_instruction, 16'h9000);
      chk("rst_valid", bus.instruction_valid, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_ovf", bus.overflow_error, 1'b0);
      chk("rst_ready", bus.load_byte_ready, 1'b1);
      chk("rst_pc", bus.program_counter, 0);

      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("load_start_ignored", {bus.busy, bus.load_byte_ready}, 2'b01);

`ifndef SINGLE_STEP_EN
      // A lone high byte followed by reset must be forgotten.
      send(8'hAB);
      do_reset();
      send(8'h12); send(8'h34); send(8'hFF); send(8'hFF);
      chk("short_ready", bus.load_byte_ready, 1'b0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("short_word", bus.current_instruction, 16'h1234);
      chk("short_valid", bus.instruction_valid, 1'b1);
      tick();
      chk("short_end_valid", bus.instruction_valid, 1'b0);
      chk("short_end_done", bus.done, 1'b1);

      do_reset();
      load_main();
      chk("main_loaded_ready", bus.load_byte_ready, 1'b0);
      chk("main_loaded_done", bus.done, 1'b0);
      run_main("run1");
      run_main("rerun");

      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("midrun_word0", bus.current_instruction, 16'h0005);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrun_rst_valid", bus.instruction_valid, 1'b0);
      chk("midrun_rst_nop", bus.current_instruction, 16'h9000);
      chk("midrun_rst_ready", bus.load_byte_ready, 1'b1);
      chk("midrun_rst_busy", bus.busy, 1'b0);

      send(8'hFF); send(8'hFF);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("empty_n1_done", bus.done, 1'b0);
      chk("empty_n1_valid", bus.instruction_valid, 1'b0);
      tick();
      chk("empty_n2_done", bus.done, 1'b1);
      chk("empty_n2_valid", bus.instruction_valid, 1'b0);

      for (int i = 0; i < 8; i++) send4(prog_ovf[i]);
      chk("ovf_flag", bus4.overflow_error, 1'b1);
      chk("ovf_ready", bus4.load_byte_ready, 1'b0);
      bus4.start = 1'b1;
      tick();
      bus4.start = 1'b0;
      chk("ovf_n1_valid", bus4.instruction_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("ovf_word%0d", i), bus4.current_instruction, exp_ovf[i]);
         chk($sformatf("ovf_valid%0d", i), bus4.instruction_valid, 1'b1);
         chk($sformatf("ovf_pc%0d", i), bus4.program_counter, i);
      end
      tick();
      chk("ovf_end_valid", bus4.instruction_valid, 1'b0);
      chk("ovf_end_nop", bus4.current_instruction, 16'h9000);
      chk("ovf_end_done", bus4.done, 1'b1);
`else
      do_reset();
      load_main();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      chk("step_armed_busy", bus.busy, 1'b1);
      chk("step_armed_valid", bus.instruction_valid, 1'b0);
      chk("step_armed_nop", bus.current_instruction, 16'h9000);
      for (int k = 0; k < 3; k++) begin
         bus.step_in = 1'b1;
         tick();
         bus.step_in = 1'b0;
         chk($sformatf("step%0d_s1_valid", k), bus.instruction_valid, 1'b0);
         tick();
         chk($sformatf("step%0d_word", k), bus.current_instruction, exp_main[k]);
         chk($sformatf("step%0d_valid", k), bus.instruction_valid, 1'b1);
         chk($sformatf("step%0d_pc", k), bus.program_counter, k);
         tick();
         chk($sformatf("step%0d_s3_valid", k), bus.instruction_valid, 1'b0);
         chk($sformatf("step%0d_s3_nop", k), bus.current_instruction, 16'h9000);
         tick();
      end
      chk("step_before_halt_busy", bus.busy, 1'b1);
      bus.step_in = 1'b1;
      tick();
      bus.step_in = 1'b0;
      tick();
      chk("step_halt_done", bus.done, 1'b1);
      chk("step_halt_valid", bus.instruction_valid, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
